// File: rtl/fdiv_seq_if.sv
// Handshake bundle between FPU dispatch, the sequential divider and result writeback.
// master = dispatch/writeback side, slave = divider.
interface fdiv_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/fdiv_seq.sv
// Sequential single-precision divider y = x1 / x2: reciprocal of x2 from finv,
// then one mantissa multiply, normalise and round-to-nearest on the guard bit.

// Pipelined reciprocal. x is sampled combinationally, so y is valid NSTAGE edges
// after x becomes stable when sampled on that edge (NSTAGE-1 register stages).
module finv #(
  parameter int NSTAGE = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  output logic [31:0] y
);
  localparam logic [48:0] NUM = 49'h1_0000_0000_0000;

  logic [48:0] quot;
  logic [31:0] res;
  logic        unused_quot;
  logic [31:0] pipe [NSTAGE-1];

  // 2^48 / {1,m} lies in (2^24, 2^25]; the top bit is set only for m == 0.
  always_comb begin
    quot = NUM / {25'd0, 1'b1, x[22:0]};
    if (x[22:0] == 23'd0)
      res = {x[31], 8'd254 - x[30:23], 23'd0};
    else if (x[30:23] > 8'd253)
      res = {x[31], 31'd0};
    else
      res = {x[31], 8'd253 - x[30:23], quot[23:1]};
  end

  assign unused_quot = ^{quot[48:24], quot[0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NSTAGE - 1; i++) pipe[i] <= 32'd0;
    end else begin
      pipe[0] <= res;
      for (int i = 1; i < NSTAGE - 1; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign y = pipe[NSTAGE-2];
endmodule

// state | meaning
// IDLE  | ready for operands
// INV   | x2 held on finv, waiting INV_LAT cycles
// MUL   | mantissa product and exponent sum
// PACK  | normalise, round, range check into y
// DONE  | y presented until out_ready
module fdiv_seq #(
  parameter int INV_LAT = 3
) (
  input logic       clk,
  input logic       rst,
  fdiv_seq_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INV  = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_PACK = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int            CW       = $clog2(INV_LAT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(INV_LAT - 1);

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [31:0]       op1, op2, r_inv, y_reg, spec_val;
  logic              spec_hit, sign, out_valid_reg;
  logic signed [9:0] exp_sum;
  logic [47:0]       prod;
  logic [31:0]       finv_y;

  logic              sp_sign, sp_hit;
  logic [31:0]       sp_val, inf_val, zero_val;

  logic signed [9:0] exp_n, exp_f;
  logic [22:0]       mant, mant_r;
  logic              guard;
  logic [24:0]       rounded;
  logic [31:0]       pack_val;
  logic              unused_bits;

  finv #(.NSTAGE(INV_LAT)) u_finv (
    .clk  (clk),
    .rstn (~rst),
    .x    (op2),
    .y    (finv_y)
  );

  // Special operands are resolved at accept and bypass the arithmetic.
  always_comb begin
    sp_sign  = bus.x1[31] ^ bus.x2[31];
    inf_val  = {sp_sign, 8'hFF, 23'd0};
    zero_val = {sp_sign, 31'd0};
    sp_hit   = 1'b1;
    sp_val   = inf_val;
    if (bus.x2[30:23] == 8'h00)
      sp_val = inf_val;
    else if (bus.x2[30:23] == 8'hFF)
      sp_val = zero_val;
    else if (bus.x1[30:23] == 8'h00)
      sp_val = zero_val;
    else if (bus.x1[30:23] == 8'hFF)
      sp_val = inf_val;
    else
      sp_hit = 1'b0;
  end

  always_comb begin
    if (prod[47]) begin
      mant  = prod[46:24];
      guard = prod[23];
      exp_n = exp_sum + 10'sd1;
    end else begin
      mant  = prod[45:23];
      guard = prod[22];
      exp_n = exp_sum;
    end
    rounded = {2'b01, mant} + {24'd0, guard};
    if (rounded[24]) begin
      mant_r = 23'd0;
      exp_f  = exp_n + 10'sd1;
    end else begin
      mant_r = rounded[22:0];
      exp_f  = exp_n;
    end
    if (exp_f >= 10'sd255)
      pack_val = {sign, 8'hFF, 23'd0};
    else if (exp_f <= 10'sd0)
      pack_val = {sign, 31'd0};
    else
      pack_val = {sign, exp_f[7:0], mant_r};
  end

  assign unused_bits = ^{prod[21:0], rounded[23]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      op1           <= 32'd0;
      op2           <= 32'd0;
      r_inv         <= 32'd0;
      y_reg         <= 32'd0;
      spec_val      <= 32'd0;
      spec_hit      <= 1'b0;
      sign          <= 1'b0;
      out_valid_reg <= 1'b0;
      exp_sum       <= '0;
      prod          <= 48'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op1      <= bus.x1;
            op2      <= bus.x2;
            spec_hit <= sp_hit;
            spec_val <= sp_val;
            cnt      <= '0;
            state    <= S_INV;
          end
        end
        S_INV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            r_inv <= finv_y;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          sign    <= op1[31] ^ r_inv[31];
          exp_sum <= $signed({2'b00, op1[30:23]}) + $signed({2'b00, r_inv[30:23]}) - 10'sd127;
          prod    <= {24'd0, 1'b1, op1[22:0]} * {24'd0, 1'b1, r_inv[22:0]};
          state   <= S_PACK;
        end
        S_PACK: begin
          y_reg         <= spec_hit ? spec_val : pack_val;
          out_valid_reg <= 1'b1;
          state         <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE) && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.y         = y_reg;
endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: latency, arithmetic, specials, range limits,
// output backpressure and reset in the middle of an operation.
module tb_fdiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fdiv_seq_if bus ();

  fdiv_seq #(.INV_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drives one operation from an idle block; lat counts edges from accept to out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic rdy,
                        output logic [31:0] res, output int lat);
    @(posedge clk); #1;
    bus.x1 = a; bus.x2 = b; bus.in_valid = 1'b1; bus.out_ready = rdy;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.y;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.y !== 32'd0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: out_valid=%b y=%h in_ready=%b, want 0/00000000/0",
               bus.out_valid, bus.y, bus.in_ready);
    end
    @(posedge clk); #1; rst = 1'b0; #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] res; int lat;
    run_op(32'h3F800000, 32'h40000000, 1'b1, res, lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
    checks++;
    if (res !== 32'h3F000000) begin errors++; $display("FAIL basic_1_div_2: got %h want 3F000000", res); end
  endtask

  task automatic test_arith();
    logic [31:0] a [3] = '{32'h40A00000, 32'hC0400000, 32'h40400000};
    logic [31:0] b [3] = '{32'h40800000, 32'h3F000000, 32'h3F800000};
    logic [31:0] e [3] = '{32'h3FA00000, 32'hC0C00000, 32'h40400000};
    logic [31:0] res; int lat; int d;
    for (int i = 0; i < 3; i++) begin
      run_op(a[i], b[i], 1'b1, res, lat);
      checks++;
      if (res !== e[i]) begin
        errors++;
        $display("FAIL arith_%0d: %h/%h got %h want %h", i, a[i], b[i], res, e[i]);
      end
    end
    run_op(32'h40C00000, 32'h40400000, 1'b1, res, lat);
    d = int'(res) - int'(32'h40000000);
    checks++;
    if (d < -2 || d > 2) begin
      errors++;
      $display("FAIL arith_6_div_3: got %h want 40000000 within 2 ulp", res);
    end
  endtask

  task automatic test_specials();
    logic [31:0] a [8] = '{32'hC0800000, 32'h3F800000, 32'h7F000000, 32'h00800000,
                          32'h00000000, 32'h7F800000, 32'h80000000, 32'h3F800000};
    logic [31:0] b [8] = '{32'h00000000, 32'h7F800000, 32'h00800000, 32'h7F000000,
                          32'h00000000, 32'h3F800000, 32'h3F800000, 32'hFF800000};
    logic [31:0] e [8] = '{32'hFF800000, 32'h00000000, 32'h7F800000, 32'h00000000,
                          32'h7F800000, 32'h7F800000, 32'h80000000, 32'h80000000};
    logic [31:0] res; int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(a[i], b[i], 1'b1, res, lat);
      checks++;
      if (res !== e[i] || lat !== 5) begin
        errors++;
        $display("FAIL special_%0d: %h/%h got %h lat %0d want %h lat 5", i, a[i], b[i], res, lat, e[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res; int lat; int bad;
    run_op(32'h40400000, 32'h3F800000, 1'b0, res, lat);
    checks++;
    if (res !== 32'h40400000 || lat !== 5) begin
      errors++;
      $display("FAIL bp_result: got %h lat %0d want 40400000 lat 5", res, lat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.x1 = 32'h41200000 + i;
      bus.x2 = 32'h40000000;
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.y !== 32'h40400000 || bus.in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d of 10 cycles unstable, want y=40400000 out_valid=1 in_ready=0", bad);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.y !== 32'h40400000) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b y=%h want 0/1/40400000",
               bus.out_valid, bus.in_ready, bus.y);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res; int lat; int seen;
    @(posedge clk); #1;
    bus.x1 = 32'h40A00000; bus.x2 = 32'h40800000; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.y !== 32'd0) begin
      errors++;
      $display("FAIL midop_reset: out_valid=%b y=%h want 0/00000000", bus.out_valid, bus.y);
    end
    @(posedge clk); #1; rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midop_discard: %0d cycles with out_valid/in_ready wrong, want 0", seen);
    end
    run_op(32'h3F800000, 32'h40000000, 1'b1, res, lat);
    checks++;
    if (res !== 32'h3F000000 || lat !== 5) begin
      errors++;
      $display("FAIL midop_recover: got %h lat %0d want 3F000000 lat 5", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; int l1, l2;
    run_op(32'h40400000, 32'h3F000000, 1'b1, r1, l1);
    run_op(32'hBF800000, 32'h40800000, 1'b1, r2, l2);
    checks++;
    if (r1 !== 32'h40C00000 || l1 !== 5) begin
      errors++;
      $display("FAIL b2b_first: got %h lat %0d want 40C00000 lat 5", r1, l1);
    end
    checks++;
    if (r2 !== 32'hBE800000 || l2 !== 5) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d want BE800000 lat 5", r2, l2);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.x1 = 32'd0; bus.x2 = 32'd0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_arith();
    test_specials();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
